// File: rtl/en_greater_less.sv
// ============================================================================
// Module      : en_greater_less
// Description : Registered unsigned magnitude comparator with enable, built
//               as an MSB-to-LSB bit-slice cascade.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module en_greater_less #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [5:0]       s,
    input  logic             EN,
    input  logic             clk,
    input  logic             rst
);

    localparam logic [5:0] c_FLAGS_CLEAR = 6'b000000;

    // Index WIDTH is the cascade seed: nothing decided yet, operands "equal so far".
    logic [WIDTH:0] w_gt;
    logic [WIDTH:0] w_lt;
    logic [WIDTH:0] w_eq;
    logic [5:0]     w_flags;
    logic [5:0]     r_s;

    assign w_gt[WIDTH] = 1'b0;
    assign w_lt[WIDTH] = 1'b0;
    assign w_eq[WIDTH] = 1'b1;

    // A slice only resolves the order when every more significant bit matched.
    generate
        for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
            assign w_gt[i] = w_gt[i+1] | (w_eq[i+1] &  a[i] & ~b[i]);
            assign w_lt[i] = w_lt[i+1] | (w_eq[i+1] & ~a[i] &  b[i]);
            assign w_eq[i] = w_eq[i+1] & ~(a[i] ^ b[i]);
        end
    endgenerate

    assign w_flags = {~w_eq[0],
                      w_lt[0] | w_eq[0],
                      w_gt[0] | w_eq[0],
                      w_eq[0],
                      w_lt[0],
                      w_gt[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= c_FLAGS_CLEAR;
        end else if (EN) begin
            r_s <= w_flags;
        end else begin
            r_s <= c_FLAGS_CLEAR;
        end
    end

    assign s = r_s;

endmodule

`default_nettype wire

// File: tb/tb_en_greater_less.sv
// ============================================================================
// Module      : tb_en_greater_less
// Description : Self-checking bench for en_greater_less (directed + random).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_en_greater_less;

    localparam int WIDTH = 8;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       s;
    logic             EN;
    logic             clk;
    logic             rst;

    int n_checks = 0;
    int n_fail   = 0;

    en_greater_less #(.WIDTH(WIDTH)) dut (
        .a   (a),
        .b   (b),
        .s   (s),
        .EN  (EN),
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag vector straight from the arithmetic meaning of each bit.
    function automatic logic [5:0] ref_flags(input int unsigned ra, input int unsigned rb,
                                              input logic ren, input logic rrst);
        logic [5:0] f;
        f = '0;
        if (!rrst && ren) begin
            f[0] = (ra >  rb);
            f[1] = (ra <  rb);
            f[2] = (ra == rb);
            f[3] = (ra >= rb);
            f[4] = (ra <= rb);
            f[5] = (ra != rb);
        end
        return f;
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1 time unit after it.
    task automatic step(input logic [7:0] ta, input logic [7:0] tb, input logic ten,
                        input logic trst, input string tag);
        @(negedge clk);
        a = ta; b = tb; EN = ten; rst = trst;
        @(posedge clk);
        #1;
        check(tag, s, ref_flags(ta, tb, ten, trst));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [5:0] held;

        a = '0; b = '0; EN = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", s, 6'h00);

        // Reset takes priority over EN and operands.
        step(8'hE1, 8'h55, 1'b1, 1'b1, "rst_over_en");
        check("rst_over_en_const", s, 6'h00);
        step(8'hE1, 8'h55, 1'b1, 1'b0, "first_after_rst");
        check("first_after_rst_const", s, 6'h29);

        step(8'h35, 8'h94, 1'b1, 1'b0, "less");
        check("less_const", s, 6'h32);
        step(8'hE1, 8'h55, 1'b1, 1'b0, "greater");
        check("greater_const", s, 6'h29);
        step(8'h35, 8'h94, 1'b0, 1'b0, "en_low");
        check("en_low_const", s, 6'h00);
        step(8'h35, 8'h94, 1'b1, 1'b0, "en_back");
        check("en_back_const", s, 6'h32);
        step(8'h35, 8'h35, 1'b1, 1'b0, "equal");
        check("equal_const", s, 6'h1C);

        step(8'h00, 8'h00, 1'b1, 1'b0, "bnd_zero");
        check("bnd_zero_const", s, 6'h1C);
        step(8'hFF, 8'hFF, 1'b1, 1'b0, "bnd_ones");
        check("bnd_ones_const", s, 6'h1C);
        step(8'hFF, 8'h00, 1'b1, 1'b0, "bnd_ff_00");
        check("bnd_ff_00_const", s, 6'h29);
        step(8'h00, 8'hFF, 1'b1, 1'b0, "bnd_00_ff");
        check("bnd_00_ff_const", s, 6'h32);
        step(8'h80, 8'h7F, 1'b1, 1'b0, "msb_only");
        step(8'h01, 8'h00, 1'b1, 1'b0, "lsb_only");

        // Operand changes between edges must not reach s.
        step(8'h10, 8'h20, 1'b1, 1'b0, "hold_pre");
        held = s;
        a = 8'h20; b = 8'h10;
        #2;
        check("hold_mid_cycle", s, 6'h32);
        EN = 1'b0;
        #1;
        check("hold_mid_cycle_en", s, held);

        // Reset held high across changing operands with EN=1.
        for (int k = 0; k < 4; k++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            step(ra, rb, 1'b1, 1'b1, "rst_hold");
        end

        // Random sweep, including occasional EN=0 and forced equality.
        for (int k = 0; k < 300; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
            step(ra, rb, ($urandom_range(0, 9) != 0), 1'b0, "rand");
            if (EN) begin
                n_checks++;
                assert ($countones(s[2:0]) === 1) else begin
                    n_fail++;
                    $error("FAIL rand_onehot observed=0x%02h expected=one_hot_low3", s);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/en_greater_less.md
EN_GREATER_LESS -- requirements
Module: en_greater_less

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; the function and verification below are defined for WIDTH = 8.
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: a  input  WIDTH  operand A, unsigned.
REQ-005 Port: b  input  WIDTH  operand B, unsigned.
REQ-006 Port: s  output  6  registered comparison flag vector.
REQ-007 Port: EN  input  1  enable, active-high.
REQ-008 Port declaration order SHALL be a, b, s, EN, clk, rst, so that existing positional instantiations (a, b, s, EN) stay valid.

Function
REQ-009 The comparison SHALL be unsigned magnitude over all WIDTH bits.
REQ-010 Flag map SHALL be:
- s[0] = A>B
- s[1] = A<B
- s[2] = A==B
- s[3] = A>=B
- s[4] = A<=B
- s[5] = A!=B
REQ-011 The comparison SHALL be built as a bit-slice cascade, MSB to LSB: each slice takes greater/less/equal from the slice above and emits updated greater/less/equal; s[3..5] are derived from the final cascade outputs.
REQ-012 s SHALL be registered, with 1-cycle latency: values of a, b and EN sampled at rising edge N appear on s after edge N and hold until edge N+1.
REQ-013 With EN=1 at a clock edge, s SHALL load the flag vector of REQ-010.
REQ-014 With EN=0 at a clock edge, s SHALL load 6'b000000, regardless of a and b.
REQ-015 With EN=1, exactly one of s[0], s[1], s[2] SHALL be 1, and s[3..5] SHALL always be consistent with s[0..2]:
- s[3] = s[0] | s[2]
- s[4] = s[1] | s[2]
- s[5] = ~s[2]
REQ-016 Boundaries:
- a=b=0x00 SHALL give 0x1C.
- a=b=0xFF SHALL give 0x1C.
- a=0xFF, b=0x00 SHALL give 0x29.
- a=0x00, b=0xFF SHALL give 0x32.
REQ-017 Operand changes between clock edges SHALL NOT affect s until the next rising edge.
REQ-018 The block SHALL contain no other state; there are no handshakes and no multi-cycle operations.

Reset
REQ-019 With rst=1 at a rising edge, s SHALL become 6'b000000.
REQ-020 rst SHALL take priority over EN and the operands.
REQ-021 After rst deasserts, the first rising edge with EN=1 SHALL load valid flags; there is no extra warm-up cycle.
REQ-022 rst asserted while EN=1 with changing operands SHALL hold s at 0 for every edge on which rst is high.

Verification
REQ-023 EN=1, a=0x35, b=0x94 -> one edge later s=0x32 (less, le, ne).
REQ-024 EN=1, a=0xE1, b=0x55 -> s=0x29 (greater, ge, ne).
REQ-025 EN=0, a=0x35, b=0x94 -> s=0x00; then EN=1 with the same operands -> s=0x32 on the next edge.
REQ-026 EN=1, a=b=0x35 -> s=0x1C (eq, ge, le).
REQ-027 rst=1 with EN=1, a=0xE1, b=0x55 -> s=0x00; after rst is released -> s=0x29 one edge later.
REQ-028 Exhaustive or random sweep of a and b with EN=1 -> s matches the reference unsigned compare each cycle, and REQ-015 holds.
